ram_fifo_ctrl: RTL and testbench

//  Valid/ready FIFO controller in front of the single-port-per-direction block RAM (registered read,
//  1-cycle latency, read-before-write). Owns the RAM write/read pointers, occupancy and a 2-entry

---
 rtl/ram_fifo_ctrl_if.sv | 42 ++++
 rtl/ram_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of write-side, read-side and RAM-side signals for ram_fifo_ctrl.
// Optional level output present only when RAM_FIFO_LEVEL_EN is defined.
interface ram_fifo_ctrl_if #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 256
);
    localparam int AW = $clog2(DEPTH);

    // Valid/ready: a word moves on a rising edge where valid && ready; the source holds data and
    // valid steady until that edge, and ready may depend combinationally on controller state only.
    logic [DWIDTH-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              ram_we;
    logic [AW-1:0]     ram_wr_addr;
    logic [DWIDTH-1:0] ram_wdata;
    logic [AW-1:0]     ram_rd_addr;
    logic [DWIDTH-1:0] ram_rdata;
`ifdef RAM_FIFO_LEVEL_EN
    logic [AW+1:0]     level;
`endif

    // master: the controller itself; slave: producer, consumer and RAM around it
    modport master (
        input  s_data, s_valid, m_ready, ram_rdata,
        output s_ready, m_data, m_valid, ram_we, ram_wr_addr, ram_wdata, ram_rd_addr
`ifdef RAM_FIFO_LEVEL_EN
        , output level
`endif
    );

    modport slave (
        output s_data, s_valid, m_ready, ram_rdata,
        input  s_ready, m_data, m_valid, ram_we, ram_wr_addr, ram_wdata, ram_rd_addr
`ifdef RAM_FIFO_LEVEL_EN
        , input level
`endif
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller for an external registered-read block RAM, with a 2-entry output
// buffer hiding read latency. Define RAM_FIFO_LEVEL_EN to add the registered level output.
module ram_fifo_ctrl #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 256
) (
    input logic             aclk,
    input logic             aresetn,
    ram_fifo_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       ram_cnt;
    logic              rd_pend;
    logic [1:0]        obuf_cnt;
    logic [DWIDTH-1:0] obuf_head;
    logic [DWIDTH-1:0] obuf_tail;

    logic              push;
    logic              pop;
    logic              issue;
    logic [2:0]        inflight;
    logic [AW:0]       ram_cnt_nxt;
    logic [1:0]        obuf_cnt_nxt;

    assign bus.s_ready     = aresetn && (ram_cnt != FULL_CNT);
    assign bus.m_valid     = (obuf_cnt != 2'd0);
    assign bus.m_data      = obuf_head;
    assign bus.ram_we      = push;
    assign bus.ram_wr_addr = wr_ptr;
    assign bus.ram_wdata   = bus.s_data;
    assign bus.ram_rd_addr = rd_ptr;

    assign push = bus.s_valid && bus.s_ready;
    assign pop  = bus.m_valid && bus.m_ready;

    // ram_cnt excludes this cycle's push, so a read never targets the word being written now
    always_comb begin
        inflight     = {1'b0, obuf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
        issue        = (ram_cnt != '0) && (inflight < 3'd2);
        ram_cnt_nxt  = ram_cnt + (AW+1)'(push) - (AW+1)'(issue);
        obuf_cnt_nxt = obuf_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_pend  <= 1'b0;
            obuf_cnt <= 2'd0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            ram_cnt  <= ram_cnt_nxt;
            rd_pend  <= issue;
            obuf_cnt <= obuf_cnt_nxt;
        end
    end

    // Read data arriving with rd_pend goes to the first free slot after any pop shifts the tail up
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            obuf_head <= '0;
            obuf_tail <= '0;
        end else begin
            case ({pop, rd_pend})
                2'b01: begin
                    if (obuf_cnt == 2'd0) obuf_head <= bus.ram_rdata;
                    else                  obuf_tail <= bus.ram_rdata;
                end
                2'b10: begin
                    if (obuf_cnt == 2'd2) obuf_head <= obuf_tail;
                end
                2'b11: begin
                    if (obuf_cnt == 2'd2) begin
                        obuf_head <= obuf_tail;
                        obuf_tail <= bus.ram_rdata;
                    end else begin
                        obuf_head <= bus.ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_FIFO_LEVEL_EN
    logic [AW+1:0] level_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            level_q <= '0;
        end else begin
            level_q <= (AW+2)'(ram_cnt_nxt) + (AW+2)'(issue) + (AW+2)'(obuf_cnt_nxt);
        end
    end

    assign bus.level = level_q;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural registered-read RAM and a scoreboard queue.
// Exercises level checks when RAM_FIFO_LEVEL_EN is defined.
module tb_ram_fifo_ctrl;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    ram_fifo_ctrl_if #(.DWIDTH(DW), .DEPTH(DEPTH)) bus ();

    ram_fifo_ctrl #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    // Registered-read, read-before-write RAM
    logic [DW-1:0] mem [DEPTH];
    always @(posedge aclk) begin
        bus.ram_rdata <= mem[bus.ram_rd_addr];
        if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_wdata;
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    int unsigned   push_total;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    // Scoreboard: records accepted words and checks every pop, sampled mid-cycle
    always @(negedge aclk) begin
        logic [DW-1:0] e;
        if (!aresetn) begin
            prev_stall = 1'b0;
            push_total = 0;
        end else begin
`ifdef RAM_FIFO_LEVEL_EN
            n_tests++;
            if (bus.level !== (AW+2)'(exp_q.size())) begin
                n_fail++;
                $display("FAIL level: got %0d want %0d", bus.level, exp_q.size());
            end
`endif
            if (prev_stall) begin
                n_tests++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: m_valid=%b m_data=%h want 1/%h",
                             bus.m_valid, bus.m_data, prev_data);
                end
            end
            n_tests++;
            if (bus.ram_we !== (bus.s_valid && bus.s_ready)) begin
                n_fail++;
                $display("FAIL ram_we: got %b want %b", bus.ram_we, bus.s_valid && bus.s_ready);
            end
            if (bus.s_valid && bus.s_ready) begin
                n_tests++;
                if (bus.ram_wr_addr !== push_total[AW-1:0]) begin
                    n_fail++;
                    $display("FAIL wr_addr: got %0d want %0d", bus.ram_wr_addr, push_total[AW-1:0]);
                end
                exp_q.push_back(bus.s_data);
                push_total++;
            end
            if (bus.m_valid && bus.m_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_empty: got %h want no word", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.m_data !== e) begin
                        n_fail++;
                        $display("FAIL pop_data: got %h want %h", bus.m_data, e);
                    end
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        repeat (DEPTH + 8) tick();
    endtask

    task automatic test_reset();
        aresetn     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || bus.m_data !== '0 || bus.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: m_valid=%b s_ready=%b m_data=%h ram_we=%b want 0/0/0/0",
                     bus.m_valid, bus.s_ready, bus.m_data, bus.ram_we);
        end
`ifdef RAM_FIFO_LEVEL_EN
        n_tests++;
        if (bus.level !== '0) begin
            n_fail++;
            $display("FAIL reset_level: got %0d want 0", bus.level);
        end
`endif
        aresetn = 1'b1;
        #1;
        n_tests++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", bus.s_ready);
        end
        tick();
    endtask

    task automatic test_single();
        drain();
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hA5A5;
        bus.m_ready = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (bus.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early: cycle %0d m_valid=%b want 0", k, bus.m_valid);
            end
            tick();
        end
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL single_out: m_valid=%b m_data=%h want 1/a5a5", bus.m_valid, bus.m_data);
        end
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: m_valid=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_stream();
        int seen   = 0;
        int bubble = 0;
        int first  = -1;
        drain();
        for (int i = 0; i < 1010; i++) begin
            bus.s_valid = (i < 1000);
            bus.s_data  = 16'(i);
            bus.m_ready = 1'b1;
            tick();
            if (bus.m_valid) begin
                if (first < 0) first = i;
                seen++;
            end else if (seen > 0 && seen < 1000) begin
                bubble++;
            end
        end
        bus.s_valid = 1'b0;
        n_tests++;
        if (first != 2 || seen != 1000 || bubble != 0) begin
            n_fail++;
            $display("FAIL stream: first=%0d seen=%0d bubbles=%0d want 2/1000/0", first, seen, bubble);
        end
    endtask

    task automatic test_full();
        int acc  = 0;
        int pops = 0;
        logic rose;
        drain();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'h4000 + 16'(i);
            #1;
            if (bus.s_ready) acc++;
            tick();
        end
        bus.s_valid = 1'b0;
        tick();
        n_tests++;
        if (acc != DEPTH + 2 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full: accepted=%0d s_ready=%b m_valid=%b want %0d/0/1",
                     acc, bus.s_ready, bus.m_valid, DEPTH + 2);
        end
`ifdef RAM_FIFO_LEVEL_EN
        n_tests++;
        if (bus.level !== (AW+2)'(DEPTH + 2)) begin
            n_fail++;
            $display("FAIL full_level: got %0d want %0d", bus.level, DEPTH + 2);
        end
`endif
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        rose = bus.s_ready;
        if (!rose) begin
            tick();
            rose = bus.s_ready;
        end
        n_tests++;
        if (rose !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ready_rise: got %b want 1", rose);
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.m_valid) pops++;
            tick();
        end
        n_tests++;
        if (pops != DEPTH + 1) begin
            n_fail++;
            $display("FAIL full_drain: got %0d words want %0d", pops, DEPTH + 1);
        end
    endtask

    task automatic test_simultaneous();
        int unsigned   t0;
        logic [AW-1:0] wexp;
        logic [AW-1:0] rexp;
        drain();
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h5A00;
        tick();
        bus.s_data = 16'h5A01;
        #1;
        t0   = push_total;
        wexp = AW'(t0);
        rexp = AW'(t0 - 1);
        n_tests++;
        if (bus.ram_we !== 1'b1 || bus.ram_wr_addr !== wexp || bus.ram_rd_addr !== rexp) begin
            n_fail++;
            $display("FAIL simul_addr: we=%b wr=%0d rd=%0d want 1/%0d/%0d",
                     bus.ram_we, bus.ram_wr_addr, bus.ram_rd_addr, wexp, rexp);
        end
        tick();
        bus.s_valid = 1'b0;
        n_tests++;
        if (bus.ram_rd_addr !== wexp || bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_after: rd=%0d s_ready=%b want %0d/1", bus.ram_rd_addr, bus.s_ready, wexp);
        end
`ifdef RAM_FIFO_LEVEL_EN
        n_tests++;
        if (bus.level !== (AW+2)'(2)) begin
            n_fail++;
            $display("FAIL simul_level: got %0d want 2", bus.level);
        end
`endif
        repeat (6) tick();
    endtask

    task automatic test_backpressure();
        int pushed = 0;
        int budget = 0;
        for (int cyc = 0; cyc < 60000 && pushed < 10000; cyc++) begin
            bus.s_valid = ($urandom_range(0, 99) < 70);
            bus.s_data  = 16'($urandom);
            bus.m_ready = ($urandom_range(0, 99) < 50);
            #1;
            if (bus.s_valid && bus.s_ready) pushed++;
            tick();
        end
        bus.s_valid = 1'b0;
        while ((exp_q.size() != 0 || bus.m_valid) && budget < 2000) begin
            bus.m_ready = ($urandom_range(0, 99) < 50);
            tick();
            budget++;
        end
        n_tests++;
        if (pushed != 10000 || exp_q.size() != 0 || budget >= 2000) begin
            n_fail++;
            $display("FAIL backpressure: pushed=%0d left=%0d drain_cycles=%0d want 10000/0/<2000",
                     pushed, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset_midstream();
        drain();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'hDE00 + 16'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        repeat (3) tick();
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || bus.m_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: m_valid=%b s_ready=%b m_data=%h want 0/0/0",
                     bus.m_valid, bus.s_ready, bus.m_data);
        end
`ifdef RAM_FIFO_LEVEL_EN
        n_tests++;
        if (bus.level !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_level: got %0d want 0", bus.level);
        end
`endif
        repeat (2) tick();
        aresetn = 1'b1;
        #1;
        n_tests++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release_ready: got %b want 1", bus.s_ready);
        end
        bus.m_ready = 1'b1;
        repeat (4) begin
            tick();
            n_tests++;
            if (bus.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale: m_valid=%b m_data=%h want 0", bus.m_valid, bus.m_data);
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h7777;
        tick();
        drain();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_after: left=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_simultaneous();
        test_backpressure();
        test_reset_midstream();
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
